// File: rtl/uart_sram_loader_if.sv
// uart_sram_loader_if: byte-receive handshake and SRAM write bus of the image loader
interface uart_sram_loader_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 16
);
  logic [7:0] RX_data;
  logic RX_empty;
  logic RX_enable;
  logic RX_unload;
  logic [ADDR_WIDTH-1:0] SRAM_address;
  logic [DATA_WIDTH-1:0] SRAM_write_data;
  logic SRAM_we_n;
  modport master (
    input RX_data, RX_empty,
    output RX_enable, RX_unload, SRAM_address, SRAM_write_data, SRAM_we_n
  );
  modport slave (
    output RX_data, RX_empty,
    input RX_enable, RX_unload, SRAM_address, SRAM_write_data, SRAM_we_n
  );
endinterface

// File: rtl/uart_sram_loader.sv
// uart_sram_loader: strips header lines from a UART byte stream and packs the payload into SRAM words
module uart_sram_loader #(
  parameter int ADDR_WIDTH = 18,
  parameter int BYTES_PER_WORD = 2,
  parameter int START_ADDR = 76800,
  parameter int END_ADDR = 262143,
  parameter int HEADER_LINES = 3,
  parameter int BIG_ENDIAN = 1
) (
  input logic Clock,
  input logic Resetn,
  input logic Initialize,
  input logic Enable,
  uart_sram_loader_if.master bus,
  output logic [ADDR_WIDTH:0] Word_count,
  output logic Busy,
  output logic Done
);
  localparam int DW = 8 * BYTES_PER_WORD;
  localparam int IW = BYTES_PER_WORD > 1 ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [ADDR_WIDTH-1:0] FIRST = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(END_ADDR);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES_PER_WORD - 1);
  typedef enum logic [2:0] {IDLE, HDR_WAIT, HDR_ACK, BYTE_WAIT, BYTE_ACK, WRITE, NEXT, DONE} state_t;
  state_t state, state_n;
  logic rx_en, rx_en_n, unload, unload_n, we_n, we_n_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [DW-1:0] data, data_n;
  logic [ADDR_WIDTH:0] cnt, cnt_n;
  logic [3:0] nl, nl_n;
  logic [IW-1:0] idx, idx_n, lane;
  logic last_byte, more;
  assign lane = BIG_ENDIAN != 0 ? LAST_IDX - idx : idx;
  assign last_byte = idx == LAST_IDX;
  assign more = addr < LAST;
  always_comb begin
    state_n = state;
    rx_en_n = rx_en;
    unload_n = unload;
    we_n_n = 1'b1;
    addr_n = addr;
    data_n = data;
    cnt_n = cnt;
    nl_n = nl;
    idx_n = idx;
    case (state)
      IDLE: if (Enable) begin
        rx_en_n = 1'b1;
        addr_n = FIRST;
        state_n = HEADER_LINES == 0 ? BYTE_WAIT : HDR_WAIT;
      end
      HDR_WAIT: if (!bus.RX_empty) begin
        unload_n = 1'b1;
        nl_n = bus.RX_data == 8'h0A && nl != 4'hF ? nl + 4'd1 : nl;
        state_n = HDR_ACK;
      end
      HDR_ACK: if (bus.RX_empty) begin
        unload_n = 1'b0;
        state_n = nl == 4'(HEADER_LINES) ? BYTE_WAIT : HDR_WAIT;
      end
      BYTE_WAIT: if (!bus.RX_empty) begin
        unload_n = 1'b1;
        data_n[lane*8 +: 8] = bus.RX_data;
        state_n = BYTE_ACK;
      end
      // the strobe and the count move together so the write cycle sees the new count
      BYTE_ACK: if (bus.RX_empty) begin
        unload_n = 1'b0;
        idx_n = last_byte ? '0 : idx + 1'b1;
        we_n_n = !last_byte;
        cnt_n = last_byte ? cnt + 1'b1 : cnt;
        state_n = last_byte ? WRITE : BYTE_WAIT;
      end
      WRITE: state_n = NEXT;
      NEXT: begin
        addr_n = more ? addr + 1'b1 : LAST;
        rx_en_n = more;
        state_n = more ? BYTE_WAIT : DONE;
      end
      DONE: ;
    endcase
  end
  always_ff @(posedge Clock)
    if (!Resetn || Initialize) begin
      state <= IDLE;
      rx_en <= 1'b0;
      unload <= 1'b0;
      we_n <= 1'b1;
      addr <= FIRST;
      data <= '0;
      cnt <= '0;
      nl <= '0;
      idx <= '0;
    end else begin
      state <= state_n;
      rx_en <= rx_en_n;
      unload <= unload_n;
      we_n <= we_n_n;
      addr <= addr_n;
      data <= data_n;
      cnt <= cnt_n;
      nl <= nl_n;
      idx <= idx_n;
    end
  assign bus.RX_enable = rx_en;
  assign bus.RX_unload = unload;
  assign bus.SRAM_we_n = we_n;
  assign bus.SRAM_address = addr;
  assign bus.SRAM_write_data = data;
  assign Word_count = cnt;
  assign Busy = state != IDLE && state != DONE;
  assign Done = state == DONE;
endmodule

// File: tb/tb_uart_sram_loader.sv
// tb_uart_sram_loader: directed stimulus for two loader configurations with a write scoreboard
module tb_uart_sram_loader;
  logic Clock = 1'b0;
  always #5 Clock = ~Clock;
  logic [1:0] rstn, init, en;
  logic [1:0][7:0] rx_data;
  logic [1:0] rx_empty;
  logic [18:0] wc_a, wc_b;
  logic [1:0] busy, done;
  int checks = 0;
  int errors = 0;
  logic [33:0] exp_a[$];
  logic [49:0] exp_b[$];
  uart_sram_loader_if #(.ADDR_WIDTH(18), .DATA_WIDTH(16)) ia ();
  uart_sram_loader_if #(.ADDR_WIDTH(18), .DATA_WIDTH(32)) ib ();
  assign ia.RX_data = rx_data[0];
  assign ia.RX_empty = rx_empty[0];
  assign ib.RX_data = rx_data[1];
  assign ib.RX_empty = rx_empty[1];
  wire [1:0] unl = {ib.RX_unload, ia.RX_unload};
  uart_sram_loader dut_a (
    .Clock(Clock), .Resetn(rstn[0]), .Initialize(init[0]), .Enable(en[0]),
    .bus(ia.master), .Word_count(wc_a), .Busy(busy[0]), .Done(done[0])
  );
  uart_sram_loader #(
    .ADDR_WIDTH(18), .BYTES_PER_WORD(4), .START_ADDR(10), .END_ADDR(11),
    .HEADER_LINES(0), .BIG_ENDIAN(0)
  ) dut_b (
    .Clock(Clock), .Resetn(rstn[1]), .Initialize(init[1]), .Enable(en[1]),
    .bus(ib.master), .Word_count(wc_b), .Busy(busy[1]), .Done(done[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // offer one byte, optionally stalling before it appears and before it is withdrawn
  task automatic send(input int k, input logic [7:0] b, input int gap);
    int n;
    tick(gap);
    rx_data[k] = b;
    rx_empty[k] = 1'b0;
    n = 0;
    while (unl[k] !== 1'b1 && n < 2000) begin
      tick(1);
      n++;
    end
    check("unload_rise", unl[k], 1);
    tick(gap);
    rx_empty[k] = 1'b1;
    n = 0;
    while (unl[k] !== 1'b0 && n < 2000) begin
      tick(1);
      n++;
    end
    check("unload_fall", unl[k], 0);
  endtask

  logic [33:0] prev_a, ea;
  logic [49:0] prev_b, eb;
  always @(negedge Clock) begin
    if (ia.SRAM_we_n === 1'b0) begin
      checks++;
      assert (exp_a.size() != 0) else begin
        errors++;
        $error("FAIL write_a_unexpected: observed write %0h expected none", {ia.SRAM_address, ia.SRAM_write_data});
      end
      if (exp_a.size() != 0) begin
        ea = exp_a.pop_front();
        checks++;
        assert ({ia.SRAM_address, ia.SRAM_write_data} === ea) else begin
          errors++;
          $error("FAIL write_a: observed %0h expected %0h", {ia.SRAM_address, ia.SRAM_write_data}, ea);
        end
      end
      checks++;
      assert ({ia.SRAM_address, ia.SRAM_write_data} === prev_a) else begin
        errors++;
        $error("FAIL write_a_setup: observed %0h expected %0h", {ia.SRAM_address, ia.SRAM_write_data}, prev_a);
      end
    end
    prev_a = {ia.SRAM_address, ia.SRAM_write_data};
  end
  always @(negedge Clock) begin
    if (ib.SRAM_we_n === 1'b0) begin
      checks++;
      assert (exp_b.size() != 0) else begin
        errors++;
        $error("FAIL write_b_unexpected: observed write %0h expected none", {ib.SRAM_address, ib.SRAM_write_data});
      end
      if (exp_b.size() != 0) begin
        eb = exp_b.pop_front();
        checks++;
        assert ({ib.SRAM_address, ib.SRAM_write_data} === eb) else begin
          errors++;
          $error("FAIL write_b: observed %0h expected %0h", {ib.SRAM_address, ib.SRAM_write_data}, eb);
        end
      end
      checks++;
      assert ({ib.SRAM_address, ib.SRAM_write_data} === prev_b) else begin
        errors++;
        $error("FAIL write_b_setup: observed %0h expected %0h", {ib.SRAM_address, ib.SRAM_write_data}, prev_b);
      end
    end
    prev_b = {ib.SRAM_address, ib.SRAM_write_data};
  end

  // RX_unload may only rise on a full receiver and only fall on an empty one
  logic [1:0] pu = 2'b00;
  logic [1:0] pe = 2'b11;
  int nrise [2] = '{0, 0};
  always @(negedge Clock) begin
    for (int k = 0; k < 2; k++) begin
      if (unl[k] === 1'b1 && pu[k] === 1'b0) begin
        nrise[k]++;
        checks++;
        assert (pe[k] === 1'b0) else begin
          errors++;
          $error("FAIL unload_rise_on_empty: observed empty %b expected 0", pe[k]);
        end
      end
      if (unl[k] === 1'b0 && pu[k] === 1'b1) begin
        checks++;
        assert (pe[k] === 1'b1) else begin
          errors++;
          $error("FAIL unload_fall_on_full: observed empty %b expected 1", pe[k]);
        end
      end
    end
    pu = unl;
    pe = rx_empty;
  end

  initial begin
    string hdr;
    int n0;
    rstn = 2'b00;
    init = 2'b00;
    en = 2'b00;
    rx_data = '0;
    rx_empty = 2'b11;
    tick(2);
    check("rst_we_n", ia.SRAM_we_n, 1);
    check("rst_data", ia.SRAM_write_data, 0);
    check("rst_addr", ia.SRAM_address, 76800);
    check("rst_rx_en", ia.RX_enable, 0);
    check("rst_unload", ia.RX_unload, 0);
    check("rst_wc", wc_a, 0);
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    check("rst_addr_b", ib.SRAM_address, 10);
    rstn = 2'b11;
    tick(1);
    en[0] = 1'b1;
    tick(1);
    en[0] = 1'b0;
    check("start_rx_en", ia.RX_enable, 1);
    check("start_busy", busy[0], 1);
    n0 = nrise[0];
    hdr = "P6\n320 240\n255\n";
    for (int i = 0; i < hdr.len(); i++) send(0, hdr[i], 0);
    exp_a.push_back({18'd76800, 16'h1234});
    send(0, 8'h12, 0);
    send(0, 8'h34, 0);
    check("a_we_low", ia.SRAM_we_n, 0);
    tick(1);
    check("a_we_high", ia.SRAM_we_n, 1);
    check("a_wc1", wc_a, 1);
    tick(1);
    check("a_busy", busy[0], 1);
    check("a_done0", done[0], 0);
    check("a_unloads", nrise[0] - n0, 17);
    check("a_sb_empty", exp_a.size(), 0);
    check("a_addr_next", ia.SRAM_address, 76801);
    send(0, 8'h55, 0);
    init[0] = 1'b1;
    tick(1);
    init[0] = 1'b0;
    check("init_we_n", ia.SRAM_we_n, 1);
    check("init_data", ia.SRAM_write_data, 0);
    check("init_addr", ia.SRAM_address, 76800);
    check("init_rx_en", ia.RX_enable, 0);
    check("init_unload", ia.RX_unload, 0);
    check("init_wc", wc_a, 0);
    check("init_busy", busy[0], 0);
    check("init_done", done[0], 0);
    tick(5);
    en[0] = 1'b1;
    tick(1);
    en[0] = 1'b0;
    check("restart_addr", ia.SRAM_address, 76800);
    n0 = nrise[0];
    for (int i = 0; i < 3; i++) send(0, 8'h0A, 100);
    check("slow_hdr_unloads", nrise[0] - n0, 3);
    exp_a.push_back({18'd76800, 16'hBEEF});
    send(0, 8'hBE, 0);
    send(0, 8'hEF, 0);
    tick(2);
    check("restart_wc", wc_a, 1);
    check("restart_sb_empty", exp_a.size(), 0);
    exp_a.push_back({18'd76801, 16'hC0DE});
    send(0, 8'hC0, 0);
    send(0, 8'hDE, 0);
    check("in_write", ia.SRAM_we_n, 0);
    rstn[0] = 1'b0;
    tick(1);
    check("rstw_we_n", ia.SRAM_we_n, 1);
    check("rstw_wc", wc_a, 0);
    check("rstw_busy", busy[0], 0);
    check("rstw_done", done[0], 0);
    rstn[0] = 1'b1;
    tick(2);
    check("rstw_idle", busy[0], 0);
    check("rstw_sb_empty", exp_a.size(), 0);
    en[1] = 1'b1;
    tick(1);
    en[1] = 1'b0;
    check("b_busy", busy[1], 1);
    exp_b.push_back({18'd10, 32'h04030201});
    for (int i = 1; i <= 4; i++) send(1, 8'(i), 0);
    exp_b.push_back({18'd11, 32'h08070605});
    for (int i = 5; i <= 8; i++) send(1, 8'(i), 0);
    tick(3);
    check("b_done", done[1], 1);
    check("b_rx_en", ib.RX_enable, 0);
    check("b_addr_hold", ib.SRAM_address, 11);
    check("b_wc", wc_b, 2);
    check("b_busy_done", busy[1], 0);
    check("b_sb_empty", exp_b.size(), 0);
    n0 = nrise[1];
    rx_data[1] = 8'hA4;
    rx_empty[1] = 1'b0;
    tick(50);
    check("b_no_unload", nrise[1] - n0, 0);
    en[1] = 1'b1;
    tick(1);
    en[1] = 1'b0;
    tick(2);
    check("b_done_hold", done[1], 1);
    check("b_addr_hold2", ib.SRAM_address, 11);
    rx_empty[1] = 1'b1;
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
